// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op-code constants and FSM state.
// Imported by the ALU, its combinational core, the control unit and benches.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU ops (AND/OR/ADD/SUB/SLT) with overflow and
// illegal-code detection. Ports: op, a, b in; result, ovf, illegal out.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            ovf,
    output logic            illegal
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            lt;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt   = $signed(a) < $signed(b);

    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        unique case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result = sum;
                ovf    = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            // Iterative ops are finished by the sequencer, not here.
            ALU_SRL, ALU_SLL, ALU_SRA, ALU_MUL: result = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with start/done handshake, bit-serial shifts and shift-add MUL.
// Ports: clk, rst_n, start, alu_control, in1, in2 in; busy, done, alu_result, flags out.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] alu_result,
    output logic            zero_flag,
    output logic            ovf_flag,
    output logic            illegal_op
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(XLEN);

    alu_state_e      state_q, state_d;
    logic [SHW:0]    cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            illegal_q, illegal_d;
    logic            done_q, done_d;

    logic [XLEN-1:0] core_result;
    logic            core_ovf;
    logic            core_illegal;
    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic [XLEN-1:0] shift_next;
    logic [XLEN-1:0] prod_next;

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .op      (alu_control),
        .a       (in1),
        .b       (in2),
        .result  (core_result),
        .ovf     (core_ovf),
        .illegal (core_illegal)
    );

    assign shamt    = in2[SHW-1:0];
    assign is_shift = (alu_control == ALU_SRL) || (alu_control == ALU_SLL)
                   || (alu_control == ALU_SRA);

    // One-bit shift step; SRA replicates the MSB, which stays the latched in1 MSB.
    always_comb begin
        shift_next = acc_q >> 1;
        if (op_q == ALU_SLL) begin
            shift_next = acc_q << 1;
        end else if (op_q == ALU_SRA) begin
            shift_next = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
        end
    end

    assign prod_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = alu_control;
                    if (is_shift && shamt != '0) begin
                        state_d = ST_SHIFT;
                        cnt_d   = {1'b0, shamt};
                        acc_d   = in1;
                    end else if (alu_control == ALU_MUL) begin
                        state_d  = ST_MUL;
                        cnt_d    = CNT_MUL;
                        acc_d    = '0;
                        mcand_d  = in1;
                        mplier_d = in2;
                    end else if (is_shift) begin
                        result_d  = in1;
                        zero_d    = (in1 == '0);
                        ovf_d     = 1'b0;
                        illegal_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        result_d  = core_result;
                        zero_d    = (core_result == '0);
                        ovf_d     = core_ovf;
                        illegal_d = core_illegal;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = shift_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d   = ST_IDLE;
                    result_d  = shift_next;
                    zero_d    = (shift_next == '0);
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            ST_MUL: begin
                acc_d    = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d   = ST_IDLE;
                    result_d  = prod_next;
                    zero_d    = (prod_next == '0);
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign alu_result = result_q;
    assign zero_flag  = zero_q;
    assign ovf_flag   = ovf_q;
    assign illegal_op = illegal_q;

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle ALU: XLEN-wide datapath with registered outputs and a start/done handshake.
- Adds SLL, SRA, SLT, an overflow flag and iterative shift/multiply.
- Shifts run one bit per cycle; MUL is shift-add over XLEN cycles.
- Sits between operand muxes and writeback in the multicycle core; control FSM waits on done.

Parameters:
- XLEN, 32, datapath width (≥8, power of 2).
- SHW, $clog2(XLEN), shift-amount width, derived (localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- alu_control  in  4  operation code.
- in1  in  XLEN  operand A.
- in2  in  XLEN  operand B / shift amount (in2[SHW-1:0]).
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse, result valid.
- alu_result  out  XLEN  result, held until next done.
- zero_flag  out  1  alu_result==0, registered with result.
- ovf_flag  out  1  signed overflow (ADD/SUB only, else 0).
- illegal_op  out  1  unknown code on last accepted op.

Behaviour:
- Codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
  - SRL 1000, SLL 1001, SRA 1010, MUL 1100
  - all others illegal.
- Reset (rst_n=0 at edge): busy=0, done=0, alu_result=0, zero_flag=1, ovf_flag=0, illegal_op=0, FSM→IDLE.
  - Reset aborts any in-flight op; no done is produced for it.
- Accept at edge T when start=1 and busy=0. Operands and code are latched; later input changes are ignored.
- FSM states: IDLE, SHIFT, MUL.
  - Single-cycle ops (AND/OR/ADD/SUB/SLT/illegal), or shift with shamt=0: result registered at edge T; done=1 in cycle T+1; stays in IDLE.
  - Shift with shamt=N>0: IDLE→SHIFT at T, counter=N. Each edge shifts by one bit and decrements. Leave SHIFT at edge T+N with result registered; done=1 in cycle T+N+1.
  - MUL: IDLE→MUL at T, XLEN iterations (test multiplier LSB, add multiplicand, shift). Result = low XLEN bits of the product, unsigned/signed agnostic. Registered at edge T+XLEN; done in cycle T+XLEN+1.
- busy=1 exactly while in SHIFT or MUL. busy=0 in the done cycle, so start in the done cycle is accepted (back-to-back).
- start while busy=1 is ignored entirely; no queueing.
- SLT: signed compare, result 1 or 0.
- SRA fills with the latched in1 MSB. SRL/SLL fill with 0.
- ovf_flag:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign ≠ in1 sign.
- Illegal op: alu_result=0, zero_flag=1, illegal_op=1, done pulse normal. illegal_op clears on the next legal accept.
- alu_result, zero_flag, ovf_flag and illegal_op update only on the edge that raises done; otherwise they hold.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package alu_pkg:
  - op-code localparams (ALU_AND…ALU_MUL), shared with the control unit and benches.
  - FSM state enum.
- One sub-module, alu_comb_core: purely combinational single-cycle ops plus flag generation.
- alu_multicycle holds the FSM, counter, and iterative shift/MUL registers.

Test Plan:
1. SUB in1=10, in2=7 → done in cycle T+1, alu_result=3, zero_flag=0, ovf_flag=0. Repeat with in1=in2=50 → zero_flag=1 (beq path).
2. ADD in1=0x7FFFFFFF, in2=1 → alu_result=0x80000000, ovf_flag=1. SLT in1=0xFFFFFFFF, in2=1 → alu_result=1.
3. SRL in1=0x80000000, in2=2 → busy high 2 cycles, done in cycle T+3, 0x20000000. SRA same operands → 0xE0000000. SLL shamt 0 → done T+1, result=in1.
4. MUL in1=1234, in2=5678 → done in cycle T+33, alu_result=7006652. MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. start pulses while busy are ignored; result unchanged.
5. Back-to-back: new start in the done cycle of a SRL (shamt 3) → accepted; second done follows correctly.
6. Reset asserted mid-MUL (cycle T+10) → next cycle busy=0, done never pulses, alu_result=0, zero_flag=1. Code 4'b1111 → done T+1, illegal_op=1, alu_result=0.
